// File: rtl/uart_prog_loader_if.sv
// Instruction-memory write port driven by the UART program loader.
// The loader is the master and the instruction memory is the slave.
interface uart_prog_loader_if #(
    parameter int ADDR_WIDTH = 14
);
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;

    modport master (output imem_we, imem_addr, imem_wdata);
    modport slave  (input  imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/uart_prog_loader.sv
// Boot loader: receives a framed program image over 8N1 UART and writes it into instruction memory.
// The CPU core is held in reset while a load is in progress or after a failed load.
module uart_prog_loader #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int ADDR_WIDTH = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    input  logic               start,
    uart_prog_loader_if.master imem,
    output logic               cpu_rst,
    output logic               busy,
    output logic               done,
    output logic               err
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CNT_W    = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0]      HALF_M1   = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0]      FULL_M1   = CNT_W'(BAUD_DIV - 1);
    localparam logic [16:0]           MAX_WORDS = 17'(2 ** ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE   = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    rx_state_t             rx_state;
    logic                  rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0]      rx_cnt;
    logic [2:0]            bit_idx;
    logic [7:0]            rx_byte;
    logic                  byte_valid, frame_err;

    state_t                state, next_state;
    logic [7:0]            len_lo;
    logic [15:0]           n_full;
    logic                  len_bad;
    logic [ADDR_WIDTH-1:0] last_idx, word_idx;
    logic [1:0]            byte_idx;
    logic [7:0]            sum;
    logic [31:0]           word_buf, word_next;

    // Start bit is re-checked at mid-bit so short low glitches are dropped silently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            bit_idx    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_M1) begin
                        rx_cnt   <= '0;
                        bit_idx  <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == FULL_M1) begin
                        rx_cnt  <= '0;
                        rx_byte <= {rx_sync, rx_byte[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == FULL_M1) begin
                        rx_cnt     <= '0;
                        rx_state   <= RX_IDLE;
                        byte_valid <= rx_sync;
                        frame_err  <= !rx_sync;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign n_full  = {rx_byte, len_lo};
    assign len_bad = (n_full == 16'd0) || ({1'b0, n_full} > MAX_WORDS);

    always_comb begin
        word_next = word_buf;
        word_next[{byte_idx, 3'b000} +: 8] = rx_byte;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start)
                    next_state = S_SYNC;
            end
            default: begin
                if (frame_err) begin
                    next_state = S_ERR;
                end else if (byte_valid) begin
                    case (state)
                        S_SYNC:   if (rx_byte == 8'hA5) next_state = S_LEN_LO;
                        S_LEN_LO: next_state = S_LEN_HI;
                        S_LEN_HI: next_state = len_bad ? S_ERR : S_DATA;
                        S_DATA:   if (byte_idx == 2'd3 && word_idx == last_idx) next_state = S_CSUM;
                        S_CSUM:   next_state = (rx_byte == sum) ? S_DONE : S_ERR;
                        default:  next_state = state;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        busy    = state inside {S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM};
        done    = (state == S_DONE);
        err     = (state == S_ERR);
        cpu_rst = busy | err;
    end

    // Word assembly and the one-cycle write strobe; the address/data hold between writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_lo          <= '0;
            last_idx        <= '0;
            word_idx        <= '0;
            byte_idx        <= '0;
            sum             <= '0;
            word_buf        <= '0;
            imem.imem_we    <= 1'b0;
            imem.imem_addr  <= '0;
            imem.imem_wdata <= '0;
        end else begin
            imem.imem_we <= 1'b0;
            if (byte_valid) begin
                case (state)
                    S_LEN_LO: len_lo <= rx_byte;
                    S_LEN_HI: begin
                        last_idx <= ADDR_WIDTH'(n_full - 16'd1);
                        word_idx <= '0;
                        byte_idx <= '0;
                        sum      <= '0;
                    end
                    S_DATA: begin
                        sum      <= sum + rx_byte;
                        byte_idx <= byte_idx + 2'd1;
                        word_buf <= word_next;
                        if (byte_idx == 2'd3) begin
                            imem.imem_we    <= 1'b1;
                            imem.imem_addr  <= word_idx;
                            imem.imem_wdata <= word_next;
                            word_idx        <= word_idx + IDX_ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: expected memory writes are queued as frames are sent,
// and a monitor process pops and compares them whenever the loader strobes imem_we.
module tb_uart_prog_loader;
    localparam int AW  = 2;
    localparam int DIV = 16;

    logic clk = 1'b0;
    logic rst, rx, start;
    logic cpu_rst, busy, done, err;

    uart_prog_loader_if #(.ADDR_WIDTH(AW)) imem_bus ();

    uart_prog_loader #(.CLK_FREQ(16), .BAUD(1), .ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .start   (start),
        .imem    (imem_bus),
        .cpu_rst (cpu_rst),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t        expected_q[$];
    logic [7:0] tx_q[$];
    int         passed = 0;
    int         total  = 0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
        total++;
        if (actual === required)
            passed++;
        else
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, required);
    endtask

    task automatic monitor_writes();
        wr_t exp_wr;
        forever begin
            @(negedge clk);
            if (imem_bus.imem_we === 1'b1) begin
                if (expected_q.size() == 0) begin
                    total++;
                    $display("[TB] FAIL unexpected_write: addr %0d data 0x%08h, required no write",
                             imem_bus.imem_addr, imem_bus.imem_wdata);
                end else begin
                    exp_wr = expected_q.pop_front();
                    check_output("write_addr", 32'(imem_bus.imem_addr), 32'(exp_wr.addr));
                    check_output("write_data", imem_bus.imem_wdata, exp_wr.data);
                end
            end
        end
    endtask

    task automatic expect_write(input logic [AW-1:0] addr, input logic [31:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        expected_q.push_back(w);
    endtask

    task automatic queue_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++)
            tx_q.push_back(w[8*k +: 8]);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = !bad_stop;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        if (bad_stop)
            repeat (DIV) @(negedge clk);
    endtask

    task automatic apply_stimulus();
        while (tx_q.size() > 0)
            send_byte(tx_q.pop_front(), 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic queue_nominal_frame(input logic [7:0] csum);
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h02);
        tx_q.push_back(8'h00);
        queue_word(32'h0000_0013);
        queue_word(32'h0010_0093);
        tx_q.push_back(csum);
        expect_write(2'd0, 32'h0000_0013);
        expect_write(2'd1, 32'h0010_0093);
    endtask

    initial begin
        rst   = 1'b1;
        rx    = 1'b1;
        start = 1'b0;
        fork
            monitor_writes();
        join_none
        repeat (3) @(negedge clk);
        check_output("reset_we", 32'(imem_bus.imem_we), 32'd0);
        check_output("reset_addr", 32'(imem_bus.imem_addr), 32'd0);
        check_output("reset_wdata", imem_bus.imem_wdata, 32'd0);
        check_output("reset_cpu_rst", 32'(cpu_rst), 32'd0);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_done_err", 32'({done, err}), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] nominal load");
        pulse_start();
        check_output("t1_busy", 32'(busy), 32'd1);
        check_output("t1_cpu_rst_loading", 32'(cpu_rst), 32'd1);
        queue_nominal_frame(8'hB6);
        apply_stimulus();
        check_output("t1_done", 32'(done), 32'd1);
        check_output("t1_busy_err", 32'({busy, err}), 32'd0);
        check_output("t1_cpu_rst", 32'(cpu_rst), 32'd0);
        check_output("t1_all_writes", 32'(expected_q.size()), 32'd0);

        $display("[TB] bad checksum");
        pulse_start();
        check_output("t2_rearm_done", 32'(done), 32'd0);
        check_output("t2_rearm_busy", 32'(busy), 32'd1);
        queue_nominal_frame(8'hB7);
        apply_stimulus();
        check_output("t2_err", 32'(err), 32'd1);
        check_output("t2_cpu_rst", 32'(cpu_rst), 32'd1);
        check_output("t2_done", 32'(done), 32'd0);
        check_output("t2_all_writes", 32'(expected_q.size()), 32'd0);
        pulse_start();
        check_output("t2_err_cleared", 32'(err), 32'd0);
        check_output("t2_busy_again", 32'(busy), 32'd1);

        $display("[TB] junk before sync and glitch");
        tx_q.push_back(8'h00);
        tx_q.push_back(8'hFF);
        tx_q.push_back(8'h5A);
        tx_q.push_back(8'hA5);
        apply_stimulus();
        rx = 1'b0;
        repeat (DIV / 4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        check_output("t3_glitch_busy", 32'(busy), 32'd1);
        check_output("t3_glitch_err", 32'(err), 32'd0);
        tx_q.push_back(8'h02);
        tx_q.push_back(8'h00);
        queue_word(32'h0000_0013);
        queue_word(32'h0010_0093);
        tx_q.push_back(8'hB6);
        expect_write(2'd0, 32'h0000_0013);
        expect_write(2'd1, 32'h0010_0093);
        apply_stimulus();
        check_output("t3_done", 32'(done), 32'd1);
        check_output("t3_all_writes", 32'(expected_q.size()), 32'd0);
        check_output("t3_addr_hold", 32'(imem_bus.imem_addr), 32'd1);
        check_output("t3_wdata_hold", imem_bus.imem_wdata, 32'h0010_0093);

        $display("[TB] boundary counts");
        pulse_start();
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h00);
        tx_q.push_back(8'h00);
        apply_stimulus();
        check_output("t4_n0_err", 32'(err), 32'd1);
        check_output("t4_n0_busy", 32'(busy), 32'd0);
        pulse_start();
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h05);
        tx_q.push_back(8'h00);
        apply_stimulus();
        check_output("t4_n5_err", 32'(err), 32'd1);
        pulse_start();
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h04);
        tx_q.push_back(8'h00);
        queue_word(32'h0000_0001);
        queue_word(32'h0000_0002);
        queue_word(32'h0000_0003);
        queue_word(32'h8000_0004);
        tx_q.push_back(8'h8A);
        expect_write(2'd0, 32'h0000_0001);
        expect_write(2'd1, 32'h0000_0002);
        expect_write(2'd2, 32'h0000_0003);
        expect_write(2'd3, 32'h8000_0004);
        apply_stimulus();
        check_output("t4_n4_done", 32'(done), 32'd1);
        check_output("t4_n4_all_writes", 32'(expected_q.size()), 32'd0);

        $display("[TB] framing error");
        pulse_start();
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h02);
        tx_q.push_back(8'h00);
        queue_word(32'h0000_0013);
        expect_write(2'd0, 32'h0000_0013);
        apply_stimulus();
        send_byte(8'h93, 1'b0);
        send_byte(8'h00, 1'b1);
        repeat (3) @(negedge clk);
        check_output("t5_frame_err", 32'(err), 32'd1);
        check_output("t5_frame_busy", 32'(busy), 32'd0);
        tx_q.push_back(8'h10);
        tx_q.push_back(8'h00);
        tx_q.push_back(8'hB6);
        apply_stimulus();
        check_output("t5_err_holds", 32'(err), 32'd1);
        check_output("t5_writes", 32'(expected_q.size()), 32'd0);

        $display("[TB] reset abort");
        pulse_start();
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h02);
        tx_q.push_back(8'h00);
        queue_word(32'h0000_0013);
        expect_write(2'd0, 32'h0000_0013);
        apply_stimulus();
        send_byte(8'h93, 1'b0);
        #3 rst = 1'b1;
        #1;
        check_output("t5_rst_we", 32'(imem_bus.imem_we), 32'd0);
        check_output("t5_rst_addr", 32'(imem_bus.imem_addr), 32'd0);
        check_output("t5_rst_wdata", imem_bus.imem_wdata, 32'd0);
        check_output("t5_rst_status", 32'({cpu_rst, busy, done, err}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h02);
        tx_q.push_back(8'h00);
        apply_stimulus();
        check_output("t5_idle_after_rst", 32'({cpu_rst, busy, done, err}), 32'd0);

        $display("[TB] start while busy");
        pulse_start();
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h02);
        tx_q.push_back(8'h00);
        queue_word(32'h0000_0013);
        tx_q.push_back(8'h93);
        tx_q.push_back(8'h00);
        expect_write(2'd0, 32'h0000_0013);
        expect_write(2'd1, 32'h0010_0093);
        apply_stimulus();
        pulse_start();
        check_output("t6_still_busy", 32'(busy), 32'd1);
        tx_q.push_back(8'h10);
        tx_q.push_back(8'h00);
        tx_q.push_back(8'hB6);
        apply_stimulus();
        check_output("t6_done", 32'(done), 32'd1);
        check_output("t6_all_writes", 32'(expected_q.size()), 32'd0);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
Upstream boot block for the pipelined CPU. It receives a program image over a UART serial line and writes it word-by-word into instruction memory through that memory's write port. While a load is in progress it holds the CPU core in reset. Once a load completes with a valid checksum, it releases the core, which then fetches from PC 0.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD, 115200, UART bit rate; BAUD_DIV = CLK_FREQ/BAUD (integer division, must be >= 4)
ADDR_WIDTH, 14, instruction memory word-address width; maximum image = 2^ADDR_WIDTH words

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  reset
rx  in  1  UART serial input; idle high; asynchronous to clk
start  in  1  single-cycle pulse (pre-debounced) that arms a load
imem_we  out  1  instruction memory write strobe, one cycle per word
imem_addr  out  ADDR_WIDTH  word address for the write
imem_wdata  out  32  word data for the write
cpu_rst  out  1  reset to the CPU core; high while busy or in error
busy  out  1  high from arming until DONE or ERR
done  out  1  high while in DONE
err  out  1  high while in ERR

Behaviour:
- Reset: rst is asynchronous, active-high. It forces IDLE and clears all counters.
  - Outputs during reset: imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=0, busy=0, done=0, err=0.
  - Asserting rst mid-load aborts the load. Memory keeps any words already written.
- UART receiver, 8N1, LSB first:
  - rx passes through a 2-flop synchronizer.
  - A falling edge starts a bit counter. At BAUD_DIV/2 the start bit is re-sampled; if it is high, the edge was a glitch and the receiver returns to idle with no error.
  - Data bits are sampled every BAUD_DIV cycles after that.
  - The stop bit is sampled at its midpoint. If it is low, the receiver raises a framing error.
  - byte_valid is an internal 1-cycle pulse, asserted in the cycle after the stop sample.
- Frame format:
  - Sync byte 0xA5.
  - N_lo, N_hi: 16-bit word count, little-endian.
  - N words, 4 bytes each, little-endian.
  - CSUM: 8-bit sum, modulo 256, of all payload bytes (the words only).
- FSM states and transitions:
  - IDLE: start moves to SYNC.
  - SYNC: bytes other than 0xA5 are discarded; 0xA5 moves to LEN_LO.
  - LEN_LO -> LEN_HI.
  - LEN_HI:
    - N=0 or N>2^ADDR_WIDTH: go to ERR.
    - Otherwise: go to DATA, word index=0, byte index=0, running sum=0.
  - DATA:
    - Each byte is shifted into bits [8*k+7:8*k] of the word, where k is the byte index, and added to the sum.
    - When the 4th byte arrives, the assembled word is written (see below) and the byte index returns to 0.
    - After word N-1 is written: go to CSUM.
  - CSUM: the received byte is compared with the running sum; equal goes to DONE, different goes to ERR.
  - DONE: start moves to SYNC; otherwise DONE holds.
  - ERR: start moves to SYNC; otherwise ERR holds.
  - A framing error in any state other than IDLE/DONE/ERR goes to ERR.
  - In IDLE, DONE and ERR the receiver keeps running, but its bytes are ignored.
- Word write:
  - imem_we pulses high for exactly one cycle, in the cycle after the byte_valid of the 4th byte.
  - imem_addr = word index and imem_wdata = assembled word, both valid in that same cycle.
  - The word index increments after the write; a full 2^ADDR_WIDTH-word image wraps the index to 0 after the last write, with no overflow.
  - imem_addr and imem_wdata hold their last values between writes.
- Status outputs:
  - busy=1 in SYNC, LEN_LO, LEN_HI, DATA, CSUM.
  - cpu_rst = busy | err.
  - done and err are level signals, registered, and change the cycle after the transition.
- start received while busy is ignored.
- start in DONE or ERR re-arms: done/err clear and a fresh load begins at address 0.

Test Plan:
1. Nominal load (CLK_FREQ=16, BAUD=1, BAUD_DIV=16). Send A5 02 00 | 13 00 00 00 | 93 00 10 00 | CSUM=0xB6.
   - Expect 2 imem_we pulses: addr0=0x00000013 and addr1=0x00100093.
   - done=1, cpu_rst falls to 0 one cycle after the CSUM byte_valid, busy=0, err=0.
2. Bad checksum: same frame with CSUM=0xB7.
   - Expect both words still written, then err=1, cpu_rst stays 1, done=0.
   - A start pulse then clears err and sets busy=1.
3. Junk before sync: after start, send 00 FF 5A, then the frame from test 1.
   - Expect junk ignored and identical writes/done as test 1.
   - A 0.25-bit low glitch on rx produces no byte and no error.
4. Boundary counts:
   - N=0: err=1 immediately after LEN_HI, with no imem_we.
   - ADDR_WIDTH=2, N=5: err=1 with no writes.
   - ADDR_WIDTH=2, N=4 with correct CSUM: addresses 0,1,2,3 written, then done.
5. Framing error and reset abort:
   - Stop bit driven low in the 2nd data byte: err=1 and no further writes.
   - Separately, asserting rst during word 1: all outputs return to 0 asynchronously and the FSM is in IDLE.
6. start while busy: pulse start in mid-DATA. Expect no effect, with the address sequence continuing uninterrupted.
